// File: rtl/program_sayaci_ureticisi.sv
// ============================================================================
//  Module      : program_sayaci_ureticisi
//  Description : Fetch-stage program counter generator. Holds the current PC,
//                selects the next PC from sequential +2/+4, the predicted
//                target or the execute-stage correction, drives the fetch
//                valid/ready handshake and pulses a flush after each redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_sayaci_ureticisi #(
  parameter logic [31:0] BASLANGIC_ADRESI = 32'h4000_0000,
  parameter int          SAYAC_GENISLIGI  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       durdur_i,
  input  logic                       dallanma_hata_i,
  input  logic [31:0]                duzeltilmis_ps_i,
  input  logic                       ongoru_gecerli_i,
  input  logic [31:0]                atlanan_ps_i,
  input  logic                       buyruk_16bit_i,
  input  logic                       getir_hazir_i,
  output logic [31:0]                ps_o,
  output logic                       getir_gecerli_o,
  output logic                       getir_iptal_o,
  output logic                       ps_ongoruldu_o,
  output logic [SAYAC_GENISLIGI-1:0] hata_sayaci_o
);

  // SIFIR: one idle cycle after reset; GETIR: issuing requests;
  // TEMIZLE: one flush bubble after a redirect.
  typedef enum logic [1:0] {
    SIFIR   = 2'd0,
    GETIR   = 2'd1,
    TEMIZLE = 2'd2
  } durum_t;

  localparam logic [SAYAC_GENISLIGI-1:0] SAYAC_DOLU = {SAYAC_GENISLIGI{1'b1}};

  durum_t      durum;
  durum_t      sonraki_durum;
  logic        kabul;
  logic [31:0] artis;
  logic [31:0] duzeltilmis_hizali;
  logic [31:0] atlanan_hizali;

  // Both redirect sources are forced to halfword alignment so bit 0 of the PC
  // can never become 1.
  assign duzeltilmis_hizali = duzeltilmis_ps_i & ~32'd1;
  assign atlanan_hizali     = atlanan_ps_i     & ~32'd1;
  assign artis              = buyruk_16bit_i ? 32'd2 : 32'd4;

  // Next-state and handshake outputs; a redirect wins over everything and
  // suppresses the request in the same cycle.
  always_comb begin
    sonraki_durum   = durum;
    getir_gecerli_o = 1'b0;
    getir_iptal_o   = 1'b0;
    case (durum)
      SIFIR: begin
        sonraki_durum = GETIR;
      end
      GETIR: begin
        getir_gecerli_o = !durdur_i && !dallanma_hata_i;
        sonraki_durum   = GETIR;
      end
      TEMIZLE: begin
        getir_iptal_o = 1'b1;
        sonraki_durum = GETIR;
      end
      default: begin
        sonraki_durum = SIFIR;
      end
    endcase
    if (dallanma_hata_i) begin
      sonraki_durum = TEMIZLE;
    end
  end

  // A request is consumed only when it is actually offered and taken.
  assign kabul = (durum == GETIR) && getir_gecerli_o && getir_hazir_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum <= SIFIR;
    end else begin
      durum <= sonraki_durum;
    end
  end

  // PC and predicted-flag register: redirect > stall > taken > sequential > hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ps_o           <= BASLANGIC_ADRESI;
      ps_ongoruldu_o <= 1'b0;
    end else if (dallanma_hata_i) begin
      ps_o           <= duzeltilmis_hizali;
      ps_ongoruldu_o <= 1'b0;
    end else if (durdur_i) begin
      ps_o           <= ps_o;
      ps_ongoruldu_o <= ps_ongoruldu_o;
    end else if (kabul && ongoru_gecerli_i) begin
      ps_o           <= atlanan_hizali;
      ps_ongoruldu_o <= 1'b1;
    end else if (kabul) begin
      ps_o           <= ps_o + artis;
      ps_ongoruldu_o <= 1'b0;
    end
  end

  // Saturating redirect counter; sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hata_sayaci_o <= '0;
    end else if (dallanma_hata_i && (hata_sayaci_o != SAYAC_DOLU)) begin
      hata_sayaci_o <= hata_sayaci_o + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_sayaci_ureticisi.sv
// ============================================================================
//  Module      : tb_program_sayaci_ureticisi
//  Description : Self-checking bench for program_sayaci_ureticisi. A second
//                instance with a 2-bit counter exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_sayaci_ureticisi;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        durdur_i, dallanma_hata_i, ongoru_gecerli_i, buyruk_16bit_i, getir_hazir_i;
  logic [31:0] duzeltilmis_ps_i, atlanan_ps_i;

  logic [31:0] ps_o, ps_o2;
  logic        getir_gecerli_o, getir_iptal_o, ps_ongoruldu_o;
  logic        getir_gecerli_o2, getir_iptal_o2, ps_ongoruldu_o2;
  logic [15:0] hata_sayaci_o;
  logic [1:0]  hata_sayaci_o2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  program_sayaci_ureticisi #(.BASLANGIC_ADRESI(BASE), .SAYAC_GENISLIGI(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .durdur_i(durdur_i), .dallanma_hata_i(dallanma_hata_i),
    .duzeltilmis_ps_i(duzeltilmis_ps_i), .ongoru_gecerli_i(ongoru_gecerli_i),
    .atlanan_ps_i(atlanan_ps_i), .buyruk_16bit_i(buyruk_16bit_i), .getir_hazir_i(getir_hazir_i),
    .ps_o(ps_o), .getir_gecerli_o(getir_gecerli_o), .getir_iptal_o(getir_iptal_o),
    .ps_ongoruldu_o(ps_ongoruldu_o), .hata_sayaci_o(hata_sayaci_o)
  );

  program_sayaci_ureticisi #(.BASLANGIC_ADRESI(BASE), .SAYAC_GENISLIGI(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .durdur_i(durdur_i), .dallanma_hata_i(dallanma_hata_i),
    .duzeltilmis_ps_i(duzeltilmis_ps_i), .ongoru_gecerli_i(ongoru_gecerli_i),
    .atlanan_ps_i(atlanan_ps_i), .buyruk_16bit_i(buyruk_16bit_i), .getir_hazir_i(getir_hazir_i),
    .ps_o(ps_o2), .getir_gecerli_o(getir_gecerli_o2), .getir_iptal_o(getir_iptal_o2),
    .ps_ongoruldu_o(ps_ongoruldu_o2), .hata_sayaci_o(hata_sayaci_o2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // started: at least one edge seen since reset; bubble: previous edge was a redirect.
  logic [31:0] m_pc;
  logic        m_pred, m_started, m_bubble;
  int          m_cnt;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_pc <= BASE; m_pred <= 1'b0; m_started <= 1'b0; m_bubble <= 1'b0; m_cnt <= 0;
    end else begin
      m_started <= 1'b1;
      if (dallanma_hata_i) begin
        m_pc     <= {duzeltilmis_ps_i[31:1], 1'b0};
        m_pred   <= 1'b0;
        m_bubble <= 1'b1;
        m_cnt    <= m_cnt + 1;
      end else begin
        m_bubble <= 1'b0;
        if (m_started && !m_bubble && !durdur_i && getir_hazir_i) begin
          if (ongoru_gecerli_i) begin
            m_pc   <= {atlanan_ps_i[31:1], 1'b0};
            m_pred <= 1'b1;
          end else begin
            m_pc   <= m_pc + (buyruk_16bit_i ? 32'd2 : 32'd4);
            m_pred <= 1'b0;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    logic exp_valid;
    exp_valid = m_started && !m_bubble && !durdur_i && !dallanma_hata_i;
    chk("ps",        ps_o,            m_pc);
    chk("valid",     {31'd0, getir_gecerli_o}, {31'd0, exp_valid});
    chk("iptal",     {31'd0, getir_iptal_o},   {31'd0, m_bubble});
    chk("ongoruldu", {31'd0, ps_ongoruldu_o},  {31'd0, m_pred});
    chk("sayac",     {16'd0, hata_sayaci_o},   (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk("sayac2",    {30'd0, hata_sayaci_o2},  (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    chk("ps2",       ps_o2,           m_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    durdur_i = 0; dallanma_hata_i = 0; ongoru_gecerli_i = 0; buyruk_16bit_i = 0;
    duzeltilmis_ps_i = 32'h0; atlanan_ps_i = 32'h0;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst_i = 1'b0;
    clr();
    getir_hazir_i = 1'b1;
    #1 rst_i = 1'b1;
    step(); step();
    chk("lit reset ps", ps_o, BASE);
    chk("lit reset valid", {31'd0, getir_gecerli_o}, 32'd0);
    chk("lit reset sayac", {16'd0, hata_sayaci_o}, 32'd0);
    rst_i = 1'b0;
    #1 chk("lit idle valid", {31'd0, getir_gecerli_o}, 32'd0);
    step();
    chk("lit first ps", ps_o, 32'h4000_0000);
    chk("lit first valid", {31'd0, getir_gecerli_o}, 32'd1);
    step(); chk("lit seq 4", ps_o, 32'h4000_0004);
    step(); chk("lit seq 8", ps_o, 32'h4000_0008);
    buyruk_16bit_i = 1; step(); chk("lit c 0A", ps_o, 32'h4000_000A);
    buyruk_16bit_i = 0; step(); chk("lit 0E", ps_o, 32'h4000_000E);
    buyruk_16bit_i = 1; step(); chk("lit c 10", ps_o, 32'h4000_0010);
    buyruk_16bit_i = 0; ongoru_gecerli_i = 1; atlanan_ps_i = 32'h4000_0101;
    step();
    chk("lit taken ps", ps_o, 32'h4000_0100);
    chk("lit taken flag", {31'd0, ps_ongoruldu_o}, 32'd1);
    ongoru_gecerli_i = 0; step();
    chk("lit after taken ps", ps_o, 32'h4000_0104);
    chk("lit after taken flag", {31'd0, ps_ongoruldu_o}, 32'd0);

    // redirect colliding with accept, prediction and stall
    dallanma_hata_i = 1; duzeltilmis_ps_i = 32'h4000_0200; ongoru_gecerli_i = 1; durdur_i = 1;
    atlanan_ps_i = 32'h4000_0400;
    step(); clr();
    chk("lit redir ps", ps_o, 32'h4000_0200);
    chk("lit redir iptal", {31'd0, getir_iptal_o}, 32'd1);
    chk("lit redir valid", {31'd0, getir_gecerli_o}, 32'd0);
    chk("lit redir sayac", {16'd0, hata_sayaci_o}, 32'd1);
    step();
    chk("lit post redir valid", {31'd0, getir_gecerli_o}, 32'd1);
    chk("lit post redir ps", ps_o, 32'h4000_0200);

    // ready low then stall: PC must hold
    getir_hazir_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit hazir hold ps", ps_o, 32'h4000_0200);
      chk("lit hazir hold valid", {31'd0, getir_gecerli_o}, 32'd1);
    end
    getir_hazir_i = 1; durdur_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lit stall ps", ps_o, 32'h4000_0200);
      chk("lit stall valid", {31'd0, getir_gecerli_o}, 32'd0);
    end
    durdur_i = 0; step();
    chk("lit release ps", ps_o, 32'h4000_0204);

    // back-to-back redirects, then counter saturation on the 2-bit instance
    dallanma_hata_i = 1; duzeltilmis_ps_i = 32'h100; step();
    duzeltilmis_ps_i = 32'h200; step();
    chk("lit b2b ps", ps_o, 32'h200);
    chk("lit b2b iptal", {31'd0, getir_iptal_o}, 32'd1);
    chk("lit b2b sayac", {16'd0, hata_sayaci_o}, 32'd3);
    chk("lit b2b sayac2", {30'd0, hata_sayaci_o2}, 32'd3);
    duzeltilmis_ps_i = 32'h301; step();
    chk("lit sat ps", ps_o, 32'h300);
    chk("lit sat sayac", {16'd0, hata_sayaci_o}, 32'd4);
    chk("lit sat sayac2", {30'd0, hata_sayaci_o2}, 32'd3);

    // 32-bit wrap of the sequential increment
    duzeltilmis_ps_i = 32'hFFFF_FFFD; step();
    chk("lit wrap load", ps_o, 32'hFFFF_FFFC);
    clr(); step(); step();
    chk("lit wrap zero", ps_o, 32'h0);

    // asynchronous reset in the middle of the flush bubble
    dallanma_hata_i = 1; duzeltilmis_ps_i = 32'h80; step(); clr();
    #2 rst_i = 1'b1;
    #1;
    chk("lit async ps", ps_o, BASE);
    chk("lit async iptal", {31'd0, getir_iptal_o}, 32'd0);
    chk("lit async valid", {31'd0, getir_gecerli_o}, 32'd0);
    chk("lit async sayac", {16'd0, hata_sayaci_o}, 32'd0);
    chk("lit async flag", {31'd0, ps_ongoruldu_o}, 32'd0);
    step(); rst_i = 1'b0;

    // mixed traffic, checked by the model only; stalls kept outside bubbles
    for (int i = 0; i < 80; i++) begin
      getir_hazir_i    = ($urandom_range(0, 3) != 0);
      ongoru_gecerli_i = ($urandom_range(0, 4) == 0);
      atlanan_ps_i     = $urandom;
      buyruk_16bit_i   = $urandom_range(0, 1) == 1;
      dallanma_hata_i  = ($urandom_range(0, 9) == 0);
      duzeltilmis_ps_i = $urandom;
      durdur_i         = ($urandom_range(0, 5) == 0) && !m_bubble && m_started;
      step();
    end
    clr(); getir_hazir_i = 1; step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
